// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC output-port round-robin arbiter.
// Port count is capped at MAX_PORTS so one fixed-width one-hot helper serves every instance.
package noc_arb_pkg;

  localparam int unsigned MAX_PORTS = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_e;

  // Callers narrow the result with a size cast to their own port count.
  function automatic logic [MAX_PORTS-1:0] onehot(input int unsigned idx);
    return MAX_PORTS'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational circular find-first: returns the first set bit of vec at or after start,
// wrapping from N-1 back to 0.
module rr_priority_picker #(
  parameter  int N     = 5,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]   upper_mask;
  logic [2*N-1:0] dbl_vec;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      upper_mask[i] = (IDX_W'(i) >= start);
    end
  end

  // Lower copy keeps only bits at or above start; upper copy supplies the wrapped-around bits.
  always_comb begin
    dbl_vec = {vec, vec & upper_mask};
    valid   = |vec;
    idx     = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl_vec[i]) begin
        idx = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter with RTS/DCTS handshake and a hold limit that
// bounds consecutive grants to one owner while others are waiting.
module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int MAX_HOLD  = 8,
  parameter int HOLD_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 dcts,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 rts
);

  localparam int               IDX_W     = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PORTS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam bit               UNLIMITED = (MAX_HOLD == 0);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_owner_q, last_owner_d;
  logic              rts_q, rts_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [NUM_PORTS-1:0] owner_oh;
  logic [NUM_PORTS-1:0] pick_vec;
  logic [IDX_W-1:0]     pick_start;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic                 fire;
  logic                 stall;
  logic                 keep_owner;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  // In SERVE the owner is masked out, so pick_valid doubles as "some other port requests".
  always_comb begin
    owner_oh   = NUM_PORTS'(onehot(32'(owner_q)));
    pick_vec   = (state_q == SERVE) ? (req & ~owner_oh) : req;
    pick_start = (state_q == SERVE) ? next_idx(owner_q) : next_idx(last_owner_q);
  end

  rr_priority_picker #(
    .N (NUM_PORTS)
  ) u_picker (
    .vec   (pick_vec),
    .start (pick_start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    fire       = rts_q & dcts;
    stall      = rts_q & ~dcts;
    keep_owner = req[owner_q] && (UNLIMITED || (hold_q != HOLD_LIM) || !pick_valid);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rts_d        = rts_q;
    hold_d       = hold_q;
    grant        = '0;
    xbar_sel     = '0;

    case (state_q)
      IDLE: begin
        rts_d = 1'b0;
        if (pick_valid) begin
          state_d = SERVE;
          owner_d = pick_idx;
          hold_d  = '0;
        end
      end

      SERVE: begin
        xbar_sel = owner_oh;
        if (fire) begin
          grant = owner_oh;
        end
        rts_d = ~fire;

        // A stalled handshake freezes everything but rts_q, which simply stays high.
        if (!stall) begin
          if (keep_owner) begin
            if (fire && !UNLIMITED && (hold_q != HOLD_LIM)) begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end else if (pick_valid) begin
            owner_d      = pick_idx;
            last_owner_d = owner_q;
            hold_d       = '0;
          end else begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            rts_d        = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        rts_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_IDX;
      rts_q        <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rts_q        <= rts_d;
      hold_q       <= hold_d;
    end
  end

  assign rts = rts_q;

  grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed cycle-by-cycle vectors for noc_rr_arbiter (5 ports, hold limit 4).
// Each row gives the inputs for one cycle and the outputs expected during that cycle.
module tb_noc_rr_arbiter;

  localparam int N = 5;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         dcts;
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_xbar;
    logic         exp_rts;
  } vec_t;

  vec_t vecs[$];

  logic         clk = 1'b0;
  logic         rst;
  logic         dcts;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] xbar_sel;
  logic         rts;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  noc_rr_arbiter #(
    .NUM_PORTS (N),
    .MAX_HOLD  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dcts     (dcts),
    .grant    (grant),
    .xbar_sel (xbar_sel),
    .rts      (rts)
  );

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  task automatic add(input logic r, input logic [N-1:0] rq, input logic d,
                     input logic [N-1:0] g, input logic [N-1:0] x, input logic t);
    vec_t v;
    v.rst       = r;
    v.req       = rq;
    v.dcts      = d;
    v.exp_grant = g;
    v.exp_xbar  = x;
    v.exp_rts   = t;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst  = v.rst;
    req  = v.req;
    dcts = v.dcts;
  endtask

  task automatic check_field(input string name, input int row,
                             input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s row %0d: got %b expected %b", name, row, act, exp);
    end
  endtask

  task automatic check_output(input int row, input vec_t v);
    check_field("grant", row, grant, v.exp_grant);
    check_field("xbar_sel", row, xbar_sel, v.exp_xbar);
    check_field("rts", row, {{(N-1){1'b0}}, rts}, {{(N-1){1'b0}}, v.exp_rts});
  endtask

  initial begin
    // Idle after reset with no requests.
    for (int i = 0; i < 10; i++) add(0, 5'b00000, 1, 5'b00000, 5'b00000, 0);

    // Single requester on port 2, retained past the hold limit.
    add(0, 5'b00100, 1, 5'b00000, 5'b00000, 0);
    add(0, 5'b00100, 1, 5'b00000, 5'b00100, 0);
    for (int k = 0; k < 5; k++) begin
      add(0, 5'b00100, 1, 5'b00100, 5'b00100, 1);
      add(0, 5'b00100, 1, 5'b00000, 5'b00100, 0);
    end
    add(0, 5'b00100, 1, 5'b00100, 5'b00100, 1);
    add(0, 5'b00000, 1, 5'b00000, 5'b00100, 0);
    add(0, 5'b00000, 1, 5'b00000, 5'b00000, 0);

    // Reset while rts is high and dcts low.
    add(0, 5'b00100, 1, 5'b00000, 5'b00000, 0);
    add(0, 5'b00100, 1, 5'b00000, 5'b00100, 0);
    add(1, 5'b00100, 0, 5'b00000, 5'b00100, 1);
    add(0, 5'b00100, 1, 5'b00000, 5'b00000, 0);
    add(0, 5'b00100, 1, 5'b00000, 5'b00100, 0);
    add(0, 5'b00000, 1, 5'b00100, 5'b00100, 1);
    add(0, 5'b00000, 1, 5'b00000, 5'b00000, 0);

    // last_owner is 2: scan from 3 picks port 3 over port 0; dropped request returns to IDLE.
    add(0, 5'b01001, 1, 5'b00000, 5'b00000, 0);
    add(0, 5'b00000, 1, 5'b00000, 5'b01000, 0);
    add(0, 5'b00000, 1, 5'b00000, 5'b00000, 0);

    // All ports requesting: four grants each, 0..4 then wrap to 0.
    add(1, 5'b00000, 1, 5'b00000, 5'b00000, 0);
    add(0, 5'b11111, 1, 5'b00000, 5'b00000, 0);
    add(0, 5'b11111, 1, 5'b00000, 5'b00001, 0);
    for (int o = 0; o < N; o++) begin
      for (int k = 0; k < 4; k++) begin
        add(0, 5'b11111, 1, oh(o), oh(o), 1);
        add(0, 5'b11111, 1, 5'b00000, oh(o), 0);
      end
    end
    add(0, 5'b11111, 1, 5'b00001, 5'b00001, 1);

    // Only port 1 left: it keeps ownership indefinitely.
    add(0, 5'b00010, 1, 5'b00000, 5'b00001, 0);
    for (int k = 0; k < 6; k++) begin
      add(0, 5'b00010, 1, 5'b00010, 5'b00010, 1);
      add(0, 5'b00010, 1, 5'b00000, 5'b00010, 0);
    end

    // Stall for 6 cycles while the request moves to port 3; grant on first dcts, then switch.
    for (int k = 0; k < 6; k++) add(0, 5'b01000, 0, 5'b00000, 5'b00010, 1);
    add(0, 5'b01000, 1, 5'b00010, 5'b00010, 1);
    add(0, 5'b01000, 1, 5'b00000, 5'b01000, 0);
    add(0, 5'b01000, 1, 5'b01000, 5'b01000, 1);

    // Owner 3 releases with 10001 -> 4; owner 4 releases with 00001 -> 0.
    add(0, 5'b10001, 1, 5'b00000, 5'b01000, 0);
    add(0, 5'b10001, 1, 5'b10000, 5'b10000, 1);
    add(0, 5'b00001, 1, 5'b00000, 5'b10000, 0);
    add(0, 5'b00001, 1, 5'b00001, 5'b00001, 1);
    add(0, 5'b00000, 1, 5'b00000, 5'b00001, 0);
    add(0, 5'b00000, 1, 5'b00000, 5'b00000, 0);

    rst  = 1'b1;
    req  = '0;
    dcts = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_rr_arbiter.md
# noc_rr_arbiter

Parametrised round-robin output-port arbiter for the NoC router. One instance per output port. It selects one of `NUM_PORTS` input requesters and drives the crossbar select. It also runs the RTS/DCTS flow-control handshake towards the downstream router. It generalises the fixed 5-port arbiter to any port count, rotates priority from the last owner, and bounds consecutive grants to one owner with a hold limit (starvation guard).

## Interface
- `NUM_PORTS`, default 5: number of requesting input ports (≥2). Index 0 is the local port; 1..4 are N, E, W, S.
- `MAX_HOLD`, default 8: maximum consecutive grants to one owner while others request. 0 means unlimited (sticky owner).
- `HOLD_W`, default `$clog2(MAX_HOLD+1)` (minimum 1): hold counter width. Derived; not overridden.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NUM_PORTS`: per-port request, level-sensitive.
- `dcts` in 1: downstream clear-to-send.
- `grant` out `NUM_PORTS`: one-hot or zero; combinational from registered state and `dcts`.
- `xbar_sel` out `NUM_PORTS`: one-hot crossbar select of the current owner; zero when IDLE.
- `rts` out 1: request-to-send, registered.

## Operation
- State: `busy` (IDLE/SERVE), `owner` (index), `last_owner`, `rts_ff`, `hold_cnt`.
- Pick function: first set bit of a request vector, scanning circularly from start index `s`. Returns none if the vector is zero.
- In IDLE:
  - `xbar_sel`, `grant`, and next `rts_ff` are 0.
  - If `req`≠0, next state is SERVE with `owner` = pick(`req`, `last_owner`+1 mod N) and `hold_cnt` cleared.
- In SERVE:
  - `xbar_sel` = onehot(`owner`).
  - `grant[owner]` = `rts_ff & dcts`.
  - Next `rts_ff` = 0 if `rts_ff & dcts`, else 1.
- Stall: if `rts_ff & !dcts`, all state except `rts_ff` holds.
- Otherwise, in order of priority:
  - Owner stays if `req[owner]` and any of the following holds: `MAX_HOLD`==0, `hold_cnt`<`MAX_HOLD`, or no other port requests.
  - Else `owner` becomes pick(`req` with the owner bit masked, `owner`+1). `last_owner` becomes the old owner and `hold_cnt` clears.
  - Else (no requests) return to IDLE and set `last_owner` = `owner`.
- `hold_cnt` increments on each grant cycle (`rts_ff & dcts`) while `owner` is unchanged. It saturates at `MAX_HOLD`.
- Requests are not latched. A request dropped before grant is lost; this is legal.

## Timing
- Reset values: `busy`=0, `owner`=0, `last_owner`=`NUM_PORTS`-1 (so the first pick starts at port 0), `rts_ff`=0, `hold_cnt`=0. Outputs: `grant`=0, `xbar_sel`=0, `rts`=0.
- A request seen in IDLE at cycle t gives `xbar_sel` at t+1 and `rts`=1 at t+2.
- With `dcts`=1 at t+2, `grant` is high at t+2. `rts` drops at t+3 and rises again at t+4 if the owner is retained. Sustained rate is one grant per two cycles.
- Owner change takes effect on the cycle after a grant cycle, or on a cycle with `rts`=0.
- `rst` asserted mid-transfer forces IDLE on the next edge regardless of `dcts`. `grant` is zero in the cycle after.
- `dcts` high while `rts` low has no effect.
- Wrap-around: the scan from index N-1 continues at index 0.
- A request on the owner port alongside other requests: the owner wins until the hold limit is reached.

## Structure
- Package `noc_arb_pkg`: `arb_state_e` {IDLE, SERVE}, plus an `onehot` helper function.
- Sub-module `rr_priority_picker`, parameter `N`. Inputs: `vec[N]`, `start` index. Outputs: `valid`, `idx`. Purely combinational (double-vector find-first).
- Top level holds the registers and the grant/select decode.

## Test plan
All scenarios use N=5, MAX_HOLD=4.
- Reset, then `req`=0: `rts`, `grant`, `xbar_sel` all 0 for 10 cycles. Assert `rst` mid-SERVE: IDLE and `rts`=0 on the next cycle.
- `req`=00100, `dcts`=1: `xbar_sel`=00100 at t+1, `rts` at t+2, `grant`=00100 at t+2, 4, 6…
- `req`=11111 held, `dcts`=1: owner sequence 0,0,0,0 then 1,1,1,1, then 2…; wraps 4→0. No port exceeds 4 consecutive grants.
- `req`=00010 only, held: owner 1 retained indefinitely past the hold limit, since no other requester exists.
- SERVE with `rts`=1, `dcts`=0 for 6 cycles, and `req` changes to another port: `owner`, `xbar_sel`, `rts` frozen. The grant occurs on the first `dcts`=1 cycle, then the switch.
- Owner 3 releases with `req`=10001: next owner is 4 (circular scan from 4). Then with owner 4 released and `req`=00001: owner is 0.
